// File: rtl/psum_accumulator.sv
// psum_accumulator: sums cfg_num_ch+1 PE FIFO words into 18 signed
// accumulators (3 rows x 6 columns), then requantises each element to int8
// and streams the tile out as three 48-bit rows over a valid/ready port.
module psum_accumulator #(
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [7:0]               cfg_num_ch_i,
    input  logic [4:0]               cfg_shift_i,
    input  logic                     cfg_relu_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    input  logic [18*PSUM_WIDTH-1:0] fifo_dout_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [47:0]              out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int NUM_ELEM = 18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_OUT
    } state_e;

    state_e                      state_q;
    logic [7:0]                  num_ch_q;
    logic [4:0]                  shift_q;
    logic                        relu_q;
    logic [7:0]                  rd_cnt_q;
    logic [7:0]                  data_cnt_q;
    logic                        rd_vld_q;
    logic [1:0]                  row_q;
    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_ELEM];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_ELEM];

    logic        rd_en;
    logic        beat_fire;
    logic        last_fire;
    logic [47:0] row_data;

    // Round-half-up, arithmetic shift, optional ReLU, saturate to int8.
    // One guard bit above the accumulator keeps the rounding add from wrapping.
    function automatic logic [7:0] requant(input logic signed [ACC_WIDTH-1:0] acc,
                                           input logic [4:0] sh,
                                           input logic relu);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] shd;
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
        end
        shd = (ext + rnd) >>> sh;
        if (relu && shd[ACC_WIDTH]) begin
            shd = '0;
        end
        if (shd > (ACC_WIDTH+1)'(127)) begin
            return 8'h7f;
        end else if (shd < (ACC_WIDTH+1)'(-128)) begin
            return 8'h80;
        end
        return shd[7:0];
    endfunction

    // Read strobe follows FIFO availability while accumulating; handshake decode.
    always_comb begin
        rd_en     = (state_q == S_ACC) && !fifo_empty_i;
        beat_fire = out_valid_q && out_ready_i;
        last_fire = beat_fire && (row_q == 2'd2);
    end

    // Each accumulator plus its sign-extended element of the current FIFO word.
    always_comb begin
        for (int i = 0; i < NUM_ELEM; i++) begin
            logic signed [PSUM_WIDTH-1:0] elem;
            elem     = fifo_dout_i[i*PSUM_WIDTH +: PSUM_WIDTH];
            acc_d[i] = acc_q[i] + {{(ACC_WIDTH-PSUM_WIDTH){elem[PSUM_WIDTH-1]}}, elem};
        end
    end

    // Requantise the six columns of the row currently being presented.
    always_comb begin
        // NOTE: every variable assigned here gets a value first, so no path leaves it unassigned and no latch is inferred.
        row_data = '0;
        for (int c = 0; c < 6; c++) begin
            logic [4:0] idx;
            idx                = {3'b000, row_q} * 5'd6 + 5'(c);
            row_data[c*8 +: 8] = requant(acc_q[idx], shift_q, relu_q);
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_valid_q ? row_data : 48'd0;
    assign out_last_o   = out_valid_q && (row_q == 2'd2);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = last_fire;

    // Tile sequencer: config capture, read issue, accumulation and row output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_ch_q    <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            rd_cnt_q    <= '0;
            data_cnt_q  <= '0;
            rd_vld_q    <= 1'b0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the accumulators are plain flops rather than a RAM, so clearing them in reset is legal and cheap.
            for (int i = 0; i < NUM_ELEM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values regardless of statement order.
            rd_vld_q <= rd_en;
            if (rd_vld_q) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    acc_q[i] <= acc_d[i];
                end
                data_cnt_q <= data_cnt_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        num_ch_q   <= cfg_num_ch_i;
                        shift_q    <= cfg_shift_i;
                        relu_q     <= cfg_relu_i;
                        rd_cnt_q   <= '0;
                        data_cnt_q <= '0;
                        for (int i = 0; i < NUM_ELEM; i++) begin
                            acc_q[i] <= '0;
                        end
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (rd_en) begin
                        rd_cnt_q <= rd_cnt_q + 8'd1;
                        if (rd_cnt_q == num_ch_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final word lands this cycle; all earlier words are already summed.
                    if (rd_vld_q && (data_cnt_q == num_ch_q)) begin
                        state_q     <= S_OUT;
                        row_q       <= 2'd0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (beat_fire) begin
                        if (row_q == 2'd2) begin
                            out_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed tiles with hand-computed int8 rows, driven
// from a small FIFO model; inputs change and outputs are sampled on negedges.
module tb_psum_accumulator;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int WW = 18 * PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [7:0]    cfg_num_ch_i;
    logic [4:0]    cfg_shift_i;
    logic          cfg_relu_i;
    logic          fifo_empty_i;
    logic          fifo_rd_en_o;
    logic [WW-1:0] fifo_dout_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [47:0]   out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;

    psum_accumulator #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cfg_num_ch_i (cfg_num_ch_i),
        .cfg_shift_i  (cfg_shift_i),
        .cfg_relu_i   (cfg_relu_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_dout_i  (fifo_dout_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // FIFO model: words pushed by the stimulus, popped on the DUT read strobe.
    logic [WW-1:0] mem [64];
    int            avail_end = 0;
    int            rd_ptr    = 0;
    int            done_cnt  = 0;
    logic          toggle_en = 1'b0;
    logic          tgl       = 1'b0;

    always @(posedge clk) begin
        if (fifo_rd_en_o) begin
            fifo_dout_i <= mem[rd_ptr[5:0]];
            rd_ptr      <= rd_ptr + 1;
        end
        if (toggle_en) tgl <= ~tgl;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    assign fifo_empty_i = (toggle_en && tgl) || (rd_ptr >= avail_end);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] fill(input int v);
        logic [WW-1:0] w;
        for (int k = 0; k < 18; k++) w[k*PW +: PW] = PW'(v);
        return w;
    endfunction

    // Element k = 8k-40, so each byte of the result identifies its element.
    function automatic logic [WW-1:0] ramp();
        logic [WW-1:0] w;
        for (int k = 0; k < 18; k++) w[k*PW +: PW] = PW'(8*k - 40);
        return w;
    endfunction

    task automatic push(input logic [WW-1:0] w);
        mem[avail_end[5:0]] = w;
        avail_end++;
    endtask

    // Run one tile starting at the current negedge and check all three beats.
    task automatic run_tile(input string tag, input logic [7:0] nch, input logic [4:0] sh,
                            input logic relu, input int stall, input logic tog, input logic poke,
                            input logic [47:0] e0, input logic [47:0] e1, input logic [47:0] e2);
        logic [47:0] exp_row [3];
        logic [47:0] cap;
        int base, d0, n;
        exp_row[0] = e0; exp_row[1] = e1; exp_row[2] = e2;
        toggle_en    = tog;
        cfg_num_ch_i = nch;
        cfg_shift_i  = sh;
        cfg_relu_i   = relu;
        start_i      = 1'b1;
        base         = rd_ptr;
        d0           = done_cnt;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy"}, 48'(busy_o), 48'd1);
        n = 0;
        while (!out_valid_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_o) begin
            check({tag, "_timeout"}, 48'd0, 48'd1);
            toggle_en = 1'b0;
            return;
        end
        for (int r = 0; r < 3; r++) begin
            if (r == 0 && stall > 0) begin
                out_ready_i = 1'b0;
                cap = out_data_o;
                for (int s = 0; s < stall; s++) begin
                    if (poke && s == 1) begin
                        cfg_num_ch_i = 8'd7;
                        cfg_shift_i  = 5'd4;
                        cfg_relu_i   = 1'b1;
                        start_i      = 1'b1;
                    end
                    @(negedge clk);
                    start_i = 1'b0;
                    check({tag, "_stall_data"}, out_data_o, cap);
                    check({tag, "_stall_valid"}, 48'(out_valid_o), 48'd1);
                end
            end
            if (r == 2 && poke) start_i = 1'b1;
            out_ready_i = 1'b1;
            #1;
            check($sformatf("%s_row%0d", tag, r), out_data_o, exp_row[r]);
            check($sformatf("%s_last%0d", tag, r), 48'(out_last_o), 48'(r == 2));
            check($sformatf("%s_done%0d", tag, r), 48'(done_o), 48'(r == 2));
            @(negedge clk);
            start_i = 1'b0;
        end
        out_ready_i = 1'b0;
        toggle_en   = 1'b0;
        check({tag, "_valid_end"}, 48'(out_valid_o), 48'd0);
        check({tag, "_busy_end"}, 48'(busy_o), 48'd0);
        check({tag, "_reads"}, 48'(rd_ptr - base), 48'(nch) + 48'd1);
        check({tag, "_done_pulses"}, 48'(done_cnt - d0), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        start_i      = 1'b0;
        cfg_num_ch_i = '0;
        cfg_shift_i  = '0;
        cfg_relu_i   = 1'b0;
        out_ready_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 48'(busy_o), 48'd0);
        check("rst_rd_en", 48'(fifo_rd_en_o), 48'd0);
        check("rst_valid", 48'(out_valid_o), 48'd0);
        check("rst_data", out_data_o, 48'd0);
        check("rst_done_last", {46'd0, done_o, out_last_o}, 48'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // One word of 100s, no shift: every byte 0x64.
        push(fill(100));
        run_tile("single", 8'd0, 5'd0, 1'b0, 0, 1'b0, 1'b0,
                 48'h646464646464, 48'h646464646464, 48'h646464646464);

        // Four words of -50, shift 2: (-200+2)>>>2 = -50.
        for (int i = 0; i < 4; i++) push(fill(-50));
        run_tile("neg_round", 8'd3, 5'd2, 1'b0, 0, 1'b0, 1'b0,
                 48'hCECECECECECE, 48'hCECECECECECE, 48'hCECECECECECE);

        // Same data with ReLU: everything clamps to zero.
        for (int i = 0; i < 4; i++) push(fill(-50));
        run_tile("relu", 8'd3, 5'd2, 1'b1, 0, 1'b0, 1'b0,
                 48'h0, 48'h0, 48'h0);

        // Element (1,3) = 30000 twice: saturates to 0x7F, rest zero.
        for (int i = 0; i < 2; i++) begin
            logic [WW-1:0] w;
            w = '0;
            w[(1*6+3)*PW +: PW] = PW'(30000);
            push(w);
        end
        run_tile("saturate", 8'd1, 5'd0, 1'b0, 0, 1'b0, 1'b0,
                 48'h0, 48'h00007F000000, 48'h0);

        // Ramp twice, shift 3: byte k = 2k-10. Without stalls, then with
        // empty toggling and a 5-cycle ready stall on the first beat.
        for (int i = 0; i < 2; i++) push(ramp());
        run_tile("ramp", 8'd1, 5'd3, 1'b0, 0, 1'b0, 1'b0,
                 48'h00FEFCFAF8F6, 48'h0C0A08060402, 48'h18161412100E);
        for (int i = 0; i < 2; i++) push(ramp());
        run_tile("ramp_stall", 8'd1, 5'd3, 1'b0, 5, 1'b1, 1'b0,
                 48'h00FEFCFAF8F6, 48'h0C0A08060402, 48'h18161412100E);

        // Reset after 2 of 4 reads: partial sums must vanish.
        for (int i = 0; i < 2; i++) push(fill(1000));
        n = rd_ptr;
        cfg_num_ch_i = 8'd3;
        cfg_shift_i  = 5'd0;
        cfg_relu_i   = 1'b0;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_reads", 48'(rd_ptr - n), 48'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 48'(busy_o), 48'd0);
        check("midrst_rd_en", 48'(fifo_rd_en_o), 48'd0);
        check("midrst_valid", 48'(out_valid_o), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_beat", {46'd0, out_valid_o, busy_o}, 48'd0);
        end
        push(fill(7));
        run_tile("after_rst", 8'd0, 5'd0, 1'b0, 0, 1'b0, 1'b0,
                 48'h070707070707, 48'h070707070707, 48'h070707070707);

        // Start during OUT with other cfg, and again on the done cycle: both ignored.
        push(fill(100));
        run_tile("poke", 8'd0, 5'd0, 1'b0, 3, 1'b0, 1'b1,
                 48'h646464646464, 48'h646464646464, 48'h646464646464);
        // A start on the very next cycle is accepted.
        push(fill(-300));
        run_tile("back2back", 8'd0, 5'd1, 1'b0, 0, 1'b0, 1'b0,
                 48'h808080808080, 48'h808080808080, 48'h808080808080);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter PSUM_WIDTH, default 16: width of one signed partial sum in the PE FIFO word.
REQ-002 Parameter ACC_WIDTH, default 24: width of each signed internal accumulator (ACC_WIDTH >= PSUM_WIDTH+8).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle pulse that begins a tile; sampled only in IDLE.
REQ-006 cfg_num_ch_i  input  8  number of FIFO words to accumulate, minus 1 (1..256); latched on accepted start.
REQ-007 cfg_shift_i  input  5  requantisation right-shift amount (0..ACC_WIDTH-1); latched on accepted start.
REQ-008 cfg_relu_i  input  1  1 = clamp negative results to 0; latched on accepted start.
REQ-009 fifo_empty_i  input  1  PE FIFO empty flag.
REQ-010 fifo_rd_en_o  output  1  PE FIFO read strobe.
REQ-011 fifo_dout_i  input  18*PSUM_WIDTH  PE FIFO word, valid the cycle after fifo_rd_en_o; element (r,c), r=0..2, c=0..5, at bits [(r*6+c)*PSUM_WIDTH +: PSUM_WIDTH].
REQ-012 out_valid_o  output  1  output row valid.
REQ-013 out_ready_i  input  1  downstream ready.
REQ-014 out_data_o  output  48  one output row; column c int8 at bits [c*8 +: 8].
REQ-015 out_last_o  output  1  high with the third (row 2) beat of a tile.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse on the cycle the row-2 beat handshakes.

Function
REQ-018 FSM states IDLE, ACC, DRAIN, OUT; IDLE->ACC on start_i; ACC->DRAIN when the last read is issued; DRAIN->OUT when the last read data is accumulated; OUT->IDLE on row-2 handshake.
REQ-019 On accepted start, all 18 accumulators SHALL clear to 0, read-issue and data counters SHALL clear to 0.
REQ-020 In ACC, fifo_rd_en_o SHALL equal !fifo_empty_i; back-to-back reads permitted; exactly cfg_num_ch+1 reads issued per tile.
REQ-021 fifo_rd_en_o SHALL be 0 in IDLE, DRAIN and OUT.
REQ-022 One cycle after each read, each accumulator SHALL add its sign-extended PSUM_WIDTH element; no saturation inside the accumulator (wrap modulo 2^ACC_WIDTH).
REQ-023 DRAIN lasts exactly one cycle after the final read.
REQ-024 Requant per element: if shift>0 add 2^(shift-1), then arithmetic right shift by shift; if relu, negatives become 0; then saturate to [-128,127].
REQ-025 In OUT, rows emitted in order 0,1,2; out_valid_o high continuously; out_data_o and out_last_o stable while out_valid_o && !out_ready_i.
REQ-026 Row advances only on out_valid_o && out_ready_i; out_valid_o SHALL go low the cycle after the row-2 handshake.
REQ-027 start_i while busy_o is high SHALL be ignored with no effect on config or state.
REQ-028 fifo_empty_i high in ACC stalls the tile indefinitely with accumulators held.
REQ-029 A start_i in the same cycle as done_o SHALL be ignored; a new tile may start the following cycle.

Reset
REQ-030 On rst_n low, regardless of state: FSM->IDLE, accumulators, counters and config registers 0; fifo_rd_en_o, out_valid_o, out_last_o, busy_o, done_o 0; out_data_o 0.
REQ-031 Reset mid-tile SHALL discard all partial results; no output beat is produced for that tile after reset release.

Verification
REQ-032 num_ch=0 (1 word), all 18 psums =100, shift=0, relu=0, FIFO non-empty -> 3 beats, every byte 100 (0x64), out_last on beat 3, done_o one pulse.
REQ-033 num_ch=3, all psums = -50 each word, shift=2, relu=0 -> sum -200, (-200+2)>>>2 = -50 (0xCE) in all bytes; with relu=1 -> all bytes 0x00.
REQ-034 num_ch=1, psum element (1,3)=30000 in both words, shift=0 -> row 1 column 3 saturates to 127 (0x7F); other zero elements -> 0x00.
REQ-035 FIFO empty toggled every other cycle and out_ready_i held low 5 cycles on beat 1 -> exactly num_ch+1 reads, out_data_o stable during stall, results unchanged vs. no-stall run.
REQ-036 Assert rst_n low after 2 of 4 reads, release, start new tile with num_ch=0, psums =7 -> outputs all 0x07, no stale contribution.
REQ-037 start_i pulsed during OUT with different cfg -> ignored; current tile output unchanged; start the cycle after done_o accepted.
